// File: rtl/vga_sync_gen_if.sv
// Pixel request / colour return / DAC output bundle for the VGA raster generator.
// Latency: none (wires only); the generator expects colour one clock after each request.
// Backpressure: none; the raster free-runs and the source must keep pace.
interface vga_sync_gen_if #(
   parameter int VIDEO_WIDTH = 3
);
   // request to the upstream pattern / framebuffer source
   logic [9:0]             req_col;
   logic [9:0]             req_row;
   logic                   req_active;
   // colour returned by the source, one clock after the request
   logic [VIDEO_WIDTH-1:0] iredv;
   logic [VIDEO_WIDTH-1:0] igrnv;
   logic [VIDEO_WIDTH-1:0] ibluv;
   // registered pin-side outputs
   logic                   ohsync;
   logic                   ovsync;
   logic                   ode;
   logic                   ofstart;
   logic [VIDEO_WIDTH-1:0] oredv;
   logic [VIDEO_WIDTH-1:0] ogrnv;
   logic [VIDEO_WIDTH-1:0] obluv;

   // generator side
   modport master (
      output req_col, req_row, req_active,
      input  iredv, igrnv, ibluv,
      output ohsync, ovsync, ode, ofstart, oredv, ogrnv, obluv
   );

   // source / pin side
   modport slave (
      input  req_col, req_row, req_active,
      output iredv, igrnv, ibluv,
      input  ohsync, ovsync, ode, ofstart, oredv, ogrnv, obluv
   );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster generator: column/row counters, pixel requests, registered sync/DE/colour out.
// Latency: 2 clocks from request coordinate to the matching output pixel and sync levels.
// Backpressure: none; never stalls, source colour must return exactly one clock after request.
module vga_sync_gen #(
   parameter int VIDEO_WIDTH      = 3,
   parameter int TOTAL_COLS       = 800,
   parameter int TOTAL_ROWS       = 525,
   parameter int ACTIVE_COLS      = 640,
   parameter int ACTIVE_ROWS      = 480,
   parameter int FRONT_PORCH_HORZ = 18,
   parameter int BACK_PORCH_HORZ  = 50,
   parameter int FRONT_PORCH_VERT = 10,
   parameter int BACK_PORCH_VERT  = 33
) (
   input  logic           clock,
   input  logic           reset,
   vga_sync_gen_if.master vid
);

   // All raster boundaries folded to 10-bit constants at elaboration.
   localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
   localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);
   localparam logic [9:0] ACT_COLS = 10'(ACTIVE_COLS);
   localparam logic [9:0] ACT_ROWS = 10'(ACTIVE_ROWS);
   localparam logic [9:0] HS_START = 10'(ACTIVE_COLS + FRONT_PORCH_HORZ);
   localparam logic [9:0] HS_END   = 10'(TOTAL_COLS - BACK_PORCH_HORZ - 1);
   localparam logic [9:0] VS_START = 10'(ACTIVE_ROWS + FRONT_PORCH_VERT);
   localparam logic [9:0] VS_END   = 10'(TOTAL_ROWS - BACK_PORCH_VERT - 1);

   logic [9:0] col;
   logic [9:0] row;

   logic       active_c;
   logic       hs_n_c;
   logic       vs_n_c;
   logic       fs_c;

   logic       s1_hs_n;
   logic       s1_vs_n;
   logic       s1_active;
   logic       s1_fs;

   // Raster counters: column every clock, row on column wrap, both wrap at frame end.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         col <= '0;
         row <= '0;
      end else if (col == COL_LAST) begin
         col <= '0;
         row <= (row == ROW_LAST) ? 10'd0 : row + 10'd1;
      end else begin
         col <= col + 10'd1;
      end
   end

   // Decode visibility, syncs and frame start straight from the counter values.
   always_comb begin
      active_c = (col < ACT_COLS) && (row < ACT_ROWS);
      hs_n_c   = !((col >= HS_START) && (col <= HS_END));
      vs_n_c   = !((row >= VS_START) && (row <= VS_END));
      fs_c     = (col == 10'd0) && (row == 10'd0);
   end

   // The request is the counter itself so the source sees it with no added delay.
   assign vid.req_col    = col;
   assign vid.req_row    = row;
   assign vid.req_active = active_c;

   // Stage 1: hold the decoded controls while the source fetches the pixel.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_hs_n   <= 1'b1;
         s1_vs_n   <= 1'b1;
         s1_active <= 1'b0;
         s1_fs     <= 1'b0;
      end else begin
         s1_hs_n   <= hs_n_c;
         s1_vs_n   <= vs_n_c;
         s1_active <= active_c;
         s1_fs     <= fs_c;
      end
   end

   // Stage 2: register pins together with the returned colour, blanking outside the active area.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vid.ohsync  <= 1'b1;
         vid.ovsync  <= 1'b1;
         vid.ode     <= 1'b0;
         vid.ofstart <= 1'b0;
         vid.oredv   <= '0;
         vid.ogrnv   <= '0;
         vid.obluv   <= '0;
      end else begin
         vid.ohsync  <= s1_hs_n;
         vid.ovsync  <= s1_vs_n;
         vid.ode     <= s1_active;
         vid.ofstart <= s1_fs;
         vid.oredv   <= s1_active ? vid.iredv : '0;
         vid.ogrnv   <= s1_active ? vid.igrnv : '0;
         vid.obluv   <= s1_active ? vid.ibluv : '0;
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: a full-size 640x480 instance for reset, startup,
// colour alignment and horizontal timing, plus a shrunken raster for frame-level timing.
module tb_vga_sync_gen;

   typedef struct packed {
      int tc; int tr; int ac; int ar; int hs0; int hs1; int vs0; int vs1;
   } geo_t;

   // Default 640x480 timing: hsync cols 658..749, vsync rows 490..491.
   localparam geo_t GF = '{800, 525, 640, 480, 658, 749, 490, 491};
   // Small raster: 20x10 total, 12x6 active, hsync cols 14..16, vsync row 7.
   localparam geo_t GS = '{20, 10, 12, 6, 14, 16, 7, 7};

   logic clock = 1'b0;
   logic rst_f;
   logic rst_s;
   bit   const_f;
   bit   const_s;

   int n_checks = 0;
   int n_errors = 0;

   vga_sync_gen_if #(.VIDEO_WIDTH(3)) bus_f ();
   vga_sync_gen_if #(.VIDEO_WIDTH(3)) bus_s ();

   vga_sync_gen #(.VIDEO_WIDTH(3)) dut_f (
      .clock (clock),
      .reset (rst_f),
      .vid   (bus_f)
   );

   vga_sync_gen #(
      .VIDEO_WIDTH(3), .TOTAL_COLS(20), .TOTAL_ROWS(10), .ACTIVE_COLS(12), .ACTIVE_ROWS(6),
      .FRONT_PORCH_HORZ(2), .BACK_PORCH_HORZ(3), .FRONT_PORCH_VERT(1), .BACK_PORCH_VERT(2)
   ) dut_s (
      .clock (clock),
      .reset (rst_s),
      .vid   (bus_s)
   );

   always #5 clock = ~clock;

   // Source models: one-clock registered return of the request (or constant 7).
   always @(posedge clock) begin
      bus_f.iredv <= const_f ? 3'd7 : bus_f.req_col[2:0];
      bus_f.igrnv <= const_f ? 3'd7 : bus_f.req_row[2:0];
      bus_f.ibluv <= const_f ? 3'd7 : 3'd5;
      bus_s.iredv <= const_s ? 3'd7 : bus_s.req_col[2:0];
      bus_s.igrnv <= const_s ? 3'd7 : bus_s.req_row[2:0];
      bus_s.ibluv <= const_s ? 3'd7 : 3'd5;
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Raster position p (clocks since frame start) to coordinate and decoded controls.
   task automatic raster(input geo_t g, input int p, output int c, output int r,
                         output int a, output int h, output int v, output int f);
      int q;
      q = p % (g.tc * g.tr);
      c = q % g.tc;
      r = q / g.tc;
      a = (c < g.ac && r < g.ar) ? 1 : 0;
      h = (c >= g.hs0 && c <= g.hs1) ? 0 : 1;
      v = (r >= g.vs0 && r <= g.vs1) ? 0 : 1;
      f = (q == 0) ? 1 : 0;
   endtask

   // n = edges since reset release: request shows position n, outputs show position n-2.
   task automatic check_edge(input string pre, input geo_t g, input int n, input bit cm,
                             input int rc, input int rr, input int ra, input int hs,
                             input int vs, input int de, input int fs,
                             input int rd, input int gn, input int bl);
      int c, r, a, h, v, f;
      raster(g, n, c, r, a, h, v, f);
      chk({pre, " req_col"}, rc, c);
      chk({pre, " req_row"}, rr, r);
      chk({pre, " req_active"}, ra, a);
      if (n < 2) begin
         c = 0; r = 0; a = 0; h = 1; v = 1; f = 0;
      end else begin
         raster(g, n - 2, c, r, a, h, v, f);
      end
      chk({pre, " ohsync"}, hs, h);
      chk({pre, " ovsync"}, vs, v);
      chk({pre, " ode"}, de, a);
      chk({pre, " ofstart"}, fs, f);
      chk({pre, " oredv"}, rd, a == 0 ? 0 : (cm ? 7 : c % 8));
      chk({pre, " ogrnv"}, gn, a == 0 ? 0 : (cm ? 7 : r % 8));
      chk({pre, " obluv"}, bl, a == 0 ? 0 : (cm ? 7 : 5));
   endtask

   task automatic check_reset(input string pre, input int rc, input int rr, input int ra,
                              input int hs, input int vs, input int de, input int fs,
                              input int rd, input int gn, input int bl);
      chk({pre, " rst req_col"}, rc, 0);
      chk({pre, " rst req_row"}, rr, 0);
      chk({pre, " rst req_active"}, ra, 1);
      chk({pre, " rst ohsync"}, hs, 1);
      chk({pre, " rst ovsync"}, vs, 1);
      chk({pre, " rst ode"}, de, 0);
      chk({pre, " rst ofstart"}, fs, 0);
      chk({pre, " rst rgb"}, rd + gn + bl, 0);
   endtask

   task automatic reset_f();
      check_reset("f", int'(bus_f.req_col), int'(bus_f.req_row), int'(bus_f.req_active),
                  int'(bus_f.ohsync), int'(bus_f.ovsync), int'(bus_f.ode), int'(bus_f.ofstart),
                  int'(bus_f.oredv), int'(bus_f.ogrnv), int'(bus_f.obluv));
   endtask

   // Full-size run from reset release; also measures horizontal timing from edge counts.
   task automatic run_full(input int edges);
      int hs_fall = -1, hs_fall2 = -1, hs_rise = -1, fs_edge = -1;
      int de_run = 0, de_first = -1;
      int prev_hs = 1;
      for (int n = 1; n <= edges; n++) begin
         @(negedge clock);
         check_edge("f", GF, n, const_f, int'(bus_f.req_col), int'(bus_f.req_row),
                    int'(bus_f.req_active), int'(bus_f.ohsync), int'(bus_f.ovsync),
                    int'(bus_f.ode), int'(bus_f.ofstart), int'(bus_f.oredv),
                    int'(bus_f.ogrnv), int'(bus_f.obluv));
         if (bus_f.ofstart && fs_edge < 0) fs_edge = n;
         if (prev_hs == 1 && bus_f.ohsync == 1'b0) begin
            if (hs_fall < 0) hs_fall = n;
            else if (hs_fall2 < 0) hs_fall2 = n;
         end
         if (prev_hs == 0 && bus_f.ohsync == 1'b1 && hs_rise < 0) hs_rise = n;
         prev_hs = int'(bus_f.ohsync);
         if (bus_f.ode) de_run++;
         else begin
            if (de_run > 0 && de_first < 0) de_first = de_run;
            de_run = 0;
         end
      end
      chk("f ofstart_edge", fs_edge, 2);
      chk("f hsync_fall_edge", hs_fall, 660);
      chk("f hsync_low_len", hs_rise - hs_fall, 92);
      chk("f line_period", hs_fall2 - hs_fall, 800);
      chk("f de_run_len", de_first, 640);
   endtask

   // Small raster over two frames: vertical timing, frame period and wrap points.
   task automatic run_small(input int edges);
      int vs_fall = -1, vs_rise = -1, fs_cnt = 0, fs1 = -1, fs2 = -1;
      int prev_vs = 1;
      for (int n = 1; n <= edges; n++) begin
         @(negedge clock);
         check_edge("s", GS, n, const_s, int'(bus_s.req_col), int'(bus_s.req_row),
                    int'(bus_s.req_active), int'(bus_s.ohsync), int'(bus_s.ovsync),
                    int'(bus_s.ode), int'(bus_s.ofstart), int'(bus_s.oredv),
                    int'(bus_s.ogrnv), int'(bus_s.obluv));
         if (n == 120) chk("s wrap_after_active_rows", int'(bus_s.req_active), 0);
         if (n == 200) begin
            chk("s frame_wrap_col", int'(bus_s.req_col), 0);
            chk("s frame_wrap_row", int'(bus_s.req_row), 0);
            chk("s frame_wrap_active", int'(bus_s.req_active), 1);
         end
         if (bus_s.ofstart) begin
            fs_cnt++;
            if (fs1 < 0) fs1 = n;
            else if (fs2 < 0) fs2 = n;
         end
         if (prev_vs == 1 && bus_s.ovsync == 1'b0 && vs_fall < 0) vs_fall = n;
         if (prev_vs == 0 && bus_s.ovsync == 1'b1 && vs_rise < 0) vs_rise = n;
         prev_vs = int'(bus_s.ovsync);
      end
      chk("s vsync_fall_edge", vs_fall, 142);
      chk("s vsync_low_len", vs_rise - vs_fall, 20);
      chk("s ofstart_count", fs_cnt, 3);
      chk("s frame_period", fs2 - fs1, 200);
   endtask

   initial begin
      rst_f   = 1'b1;
      rst_s   = 1'b1;
      const_f = 1'b1;
      const_s = 1'b1;
      repeat (3) @(negedge clock);
      reset_f();
      check_reset("s", int'(bus_s.req_col), int'(bus_s.req_row), int'(bus_s.req_active),
                  int'(bus_s.ohsync), int'(bus_s.ovsync), int'(bus_s.ode), int'(bus_s.ofstart),
                  int'(bus_s.oredv), int'(bus_s.ogrnv), int'(bus_s.obluv));

      // startup with the coordinate-echo source
      const_f = 1'b0;
      repeat (2) @(negedge clock);
      rst_f = 1'b0;
      run_full(1900);
      chk("f col_before_midline_reset", int'(bus_f.req_col), 300);

      // asynchronous reset mid-line: values must change before any clock edge
      #2 rst_f = 1'b1;
      const_f = 1'b1;
      #1 reset_f();
      repeat (2) @(negedge clock);
      reset_f();

      // restart with constant-7 source: blanking must force colour to 0
      rst_f = 1'b0;
      run_full(1602);

      // small raster, constant source across two frames
      @(negedge clock);
      rst_s = 1'b0;
      run_small(402);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
